// File: rtl/regfile_wb_scheduler.sv
// Write-port arbiter for the 32x32 register file: merges in-order core writeback with
// late multi-cycle results, keeps a busy scoreboard and raises the decode stall.
module regfile_wb_scheduler #(
  parameter int unsigned BUF_DEPTH  = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_wren_i,
  input  logic [4:0]  core_addr_i,
  input  logic [31:0] core_data_i,
  input  logic        mc_issue_i,
  input  logic [4:0]  mc_issue_addr_i,
  input  logic        mc_valid_i,
  input  logic [4:0]  mc_addr_i,
  input  logic [31:0] mc_data_i,
  output logic        mc_ready_o,
  input  logic [4:0]  dec_rs1_addr_i,
  input  logic [4:0]  dec_rs2_addr_i,
  input  logic [4:0]  dec_rd_addr_i,
  input  logic        dec_rd_en_i,
  output logic        stall_o,
  output logic        rd_wren_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic [31:0] busy_o,
  output logic        err_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned STV_W  = $clog2(STARVE_MAX + 1);

  // Result storage carries no reset; validity is tracked by the count alone.
  logic [ADDR_W-1:0] buf_addr_q [BUF_DEPTH];
  logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [31:0]       busy_q, busy_d;
  logic              err_q, err_d;

  logic              empty, full, push, pop;
  logic              core_act, forced;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [31:0]       clr_vec, set_vec, busy_keep;
  logic              hazard;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_W'(BUF_DEPTH));
  assign push      = mc_valid_i & ~full;
  assign head_addr = buf_addr_q[rd_ptr_q];
  assign head_data = buf_data_q[rd_ptr_q];

  // Core writes to x0 are treated as idle so they never hold off the buffer.
  assign core_act  = core_wren_i & (core_addr_i != '0);
  assign forced    = ~empty & (starve_q == STV_W'(STARVE_MAX));
  assign pop       = ~empty & (forced | ~core_act);

  always_comb begin
    rd_wren_o = 1'b0;
    rd_addr_o = core_addr_i;
    rd_data_o = core_data_i;
    if (pop) begin
      rd_wren_o = (head_addr != '0);
      rd_addr_o = head_addr;
      rd_data_o = head_data;
    end else if (core_act) begin
      rd_wren_o = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (pop) begin
      starve_d = '0;
    end else if (core_act && !empty && (starve_q != STV_W'(STARVE_MAX))) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // A register being committed this cycle may legally be reissued: set wins, no error.
  always_comb begin
    clr_vec   = pop        ? (32'(1) << head_addr)       : '0;
    set_vec   = mc_issue_i ? (32'(1) << mc_issue_addr_i) : '0;
    busy_keep = busy_q & ~clr_vec;
    busy_d    = (busy_keep | set_vec) & ~32'(1);
    err_d     = err_q;
    if (mc_issue_i && busy_keep[mc_issue_addr_i]) begin
      err_d = 1'b1;
    end
    if (mc_valid_i && !busy_q[mc_addr_i]) begin
      err_d = 1'b1;
    end
  end

  assign hazard = busy_q[dec_rs1_addr_i] | busy_q[dec_rs2_addr_i] |
                  (dec_rd_en_i & busy_q[dec_rd_addr_i]);

  assign stall_o    = forced | hazard;
  assign mc_ready_o = ~full;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_addr_q[wr_ptr_q] <= mc_addr_i;
      buf_data_q[wr_ptr_q] <= mc_data_i;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: scoreboard, arbitration, starvation,
// buffer full, x0 handling, error flag and asynchronous reset.
module tb_regfile_wb_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_wren_i;
  logic [4:0]  core_addr_i;
  logic [31:0] core_data_i;
  logic        mc_issue_i;
  logic [4:0]  mc_issue_addr_i;
  logic        mc_valid_i;
  logic [4:0]  mc_addr_i;
  logic [31:0] mc_data_i;
  logic        mc_ready_o;
  logic [4:0]  dec_rs1_addr_i;
  logic [4:0]  dec_rs2_addr_i;
  logic [4:0]  dec_rd_addr_i;
  logic        dec_rd_en_i;
  logic        stall_o;
  logic        rd_wren_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic [31:0] busy_o;
  logic        err_o;

  int n_chk = 0;
  int n_bad = 0;

  regfile_wb_scheduler #(.BUF_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_wren_i(core_wren_i), .core_addr_i(core_addr_i), .core_data_i(core_data_i),
    .mc_issue_i(mc_issue_i), .mc_issue_addr_i(mc_issue_addr_i),
    .mc_valid_i(mc_valid_i), .mc_addr_i(mc_addr_i), .mc_data_i(mc_data_i),
    .mc_ready_o(mc_ready_o),
    .dec_rs1_addr_i(dec_rs1_addr_i), .dec_rs2_addr_i(dec_rs2_addr_i),
    .dec_rd_addr_i(dec_rd_addr_i), .dec_rd_en_i(dec_rd_en_i),
    .stall_o(stall_o), .rd_wren_o(rd_wren_o), .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    core_wren_i = 0; core_addr_i = 0; core_data_i = 0;
    mc_issue_i = 0; mc_issue_addr_i = 0;
    mc_valid_i = 0; mc_addr_i = 0; mc_data_i = 0;
    dec_rs1_addr_i = 0; dec_rs2_addr_i = 0; dec_rd_addr_i = 0; dec_rd_en_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 0;
    tick();
    rst_ni = 1;
  endtask

  task automatic issue(input logic [4:0] a);
    mc_issue_i = 1; mc_issue_addr_i = a;
    tick();
    mc_issue_i = 0;
  endtask

  task automatic result(input logic [4:0] a, input logic [31:0] d);
    mc_valid_i = 1; mc_addr_i = a; mc_data_i = d;
    tick();
    mc_valid_i = 0;
  endtask

  initial begin
    idle_inputs();
    rst_ni = 0;
    tick(); tick();
    chk("rst_ready", mc_ready_o, 1);
    chk("rst_busy",  busy_o, 0);
    chk("rst_err",   err_o, 0);
    chk("rst_wren",  rd_wren_o, 0);
    chk("rst_stall", stall_o, 0);
    rst_ni = 1;

    // Basic mul to x5 with hazard on each decode source
    tick();
    issue(5);
    #1;
    chk("t1_busy", busy_o, 32'h20);
    dec_rs1_addr_i = 5; #1;
    chk("t1_stall_rs1", stall_o, 1);
    dec_rs1_addr_i = 0; dec_rs2_addr_i = 5; #1;
    chk("t1_stall_rs2", stall_o, 1);
    dec_rs2_addr_i = 0; dec_rd_addr_i = 5; dec_rd_en_i = 0; #1;
    chk("t1_rd_noen", stall_o, 0);
    dec_rd_en_i = 1; #1;
    chk("t1_stall_rd", stall_o, 1);
    dec_rd_en_i = 0; dec_rd_addr_i = 0; dec_rs1_addr_i = 5;
    chk("t1_ready", mc_ready_o, 1);
    result(5, 32'hDEADBEEF);
    #1;
    chk("t1_wren", rd_wren_o, 1);
    chk("t1_addr", rd_addr_o, 5);
    chk("t1_data", rd_data_o, 32'hDEADBEEF);
    chk("t1_stall_hold", stall_o, 1);
    tick();
    chk("t1_busy_clr", busy_o, 0);
    chk("t1_stall_clr", stall_o, 0);
    chk("t1_idle_wren", rd_wren_o, 0);
    chk("t1_err", err_o, 0);

    // Starvation: core writes x7 every cycle while x6 waits
    do_reset();
    issue(6);
    core_wren_i = 1; core_addr_i = 7; core_data_i = 32'h77;
    result(6, 32'h1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_core_addr", rd_addr_o, 7);
      chk("t2_core_stall", stall_o, 0);
      tick();
    end
    #1;
    chk("t2_forced_stall", stall_o, 1);
    chk("t2_forced_addr", rd_addr_o, 6);
    chk("t2_forced_data", rd_data_o, 1);
    chk("t2_forced_wren", rd_wren_o, 1);
    tick();
    chk("t2_after_addr", rd_addr_o, 7);
    chk("t2_after_stall", stall_o, 0);
    chk("t2_after_busy", busy_o, 0);

    // Buffer full with core busy; third result held off
    do_reset();
    issue(1); issue(2); issue(3);
    #1;
    chk("t3_busy", busy_o, 32'h0E);
    core_wren_i = 1; core_addr_i = 7; core_data_i = 32'h77;
    result(1, 32'h11);
    mc_valid_i = 1; mc_addr_i = 2; mc_data_i = 32'h22; #1;
    chk("t3_ready1", mc_ready_o, 1);
    tick();
    mc_addr_i = 3; mc_data_i = 32'h33; #1;
    chk("t3_full", mc_ready_o, 0);
    chk("t3_core_addr", rd_addr_o, 7);
    tick(); tick(); tick();
    chk("t3_forced_stall", stall_o, 1);
    chk("t3_forced_addr", rd_addr_o, 1);
    chk("t3_forced_data", rd_data_o, 32'h11);
    chk("t3_still_full", mc_ready_o, 0);
    tick();
    chk("t3_ready_again", mc_ready_o, 1);
    chk("t3_core_again", rd_addr_o, 7);
    chk("t3_busy2", busy_o, 32'h0C);
    tick();
    mc_valid_i = 0; core_wren_i = 0; #1;
    chk("t3_pop2_addr", rd_addr_o, 2);
    chk("t3_pop2_data", rd_data_o, 32'h22);
    tick();
    chk("t3_pop3_addr", rd_addr_o, 3);
    chk("t3_pop3_data", rd_data_o, 32'h33);
    tick();
    chk("t3_end_wren", rd_wren_o, 0);
    chk("t3_end_busy", busy_o, 0);
    chk("t3_end_err", err_o, 0);

    // x0 handling
    do_reset();
    core_wren_i = 1; core_addr_i = 0; core_data_i = 32'h99; #1;
    chk("t4_core_x0", rd_wren_o, 0);
    core_wren_i = 0;
    issue(3);
    result(3, 32'h33);
    core_wren_i = 1; #1;
    chk("t4_x3_wren", rd_wren_o, 1);
    chk("t4_x3_addr", rd_addr_o, 3);
    chk("t4_x3_data", rd_data_o, 32'h33);
    core_wren_i = 0;
    issue(4);
    result(0, 32'h55);
    mc_valid_i = 1; mc_addr_i = 4; mc_data_i = 32'h44; #1;
    chk("t4_mc_x0", rd_wren_o, 0);
    tick();
    mc_valid_i = 0; #1;
    chk("t4_x4_wren", rd_wren_o, 1);
    chk("t4_x4_addr", rd_addr_o, 4);
    chk("t4_busy_nobit0", busy_o[0], 0);

    // Reissue during commit, and issue to a busy register
    do_reset();
    issue(9);
    result(9, 32'h9);
    mc_issue_i = 1; mc_issue_addr_i = 9; #1;
    chk("t5_pop9", rd_addr_o, 9);
    tick();
    mc_issue_i = 0; #1;
    chk("t5_busy9", busy_o[9], 1);
    chk("t5_no_err", err_o, 0);
    issue(4);
    issue(4);
    #1;
    chk("t5_err", err_o, 1);
    chk("t5_busy4", busy_o[4], 1);
    tick(); tick();
    chk("t5_err_sticky", err_o, 1);

    // Asynchronous reset with two entries buffered
    do_reset();
    issue(4); issue(5);
    core_wren_i = 1; core_addr_i = 7; core_data_i = 32'h77;
    result(4, 32'h4);
    result(5, 32'h5);
    #1;
    chk("t6_busy", busy_o, 32'h30);
    chk("t6_full", mc_ready_o, 0);
    #1;
    core_wren_i = 0; rst_ni = 0; #1;
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_ready", mc_ready_o, 1);
    chk("t6_rst_wren", rd_wren_o, 0);
    chk("t6_rst_err", err_o, 0);
    tick();
    rst_ni = 1;
    tick(); tick();
    chk("t6_post_wren", rd_wren_o, 0);
    chk("t6_post_busy", busy_o, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Owns the single write port of the 32x32 register file.
- Arbitrates between the in-order core writeback and a multi-cycle unit (mul/div, load) that returns results late.
- Tracks destination registers with pending multi-cycle results in a busy scoreboard and raises a pipeline stall on RAW/WAW hazards or write-port starvation.
- Sits between the execute/writeback stages and the register file's rd_* inputs.

Parameters:
- BUF_DEPTH, 2, depth of the multi-cycle result buffer (power of 2, >=2).
- STARVE_MAX, 4, consecutive cycles a non-empty buffer may be denied before the core is stalled.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- core_wren_i  in  1  core writeback valid this cycle.
- core_addr_i  in  5  core writeback destination.
- core_data_i  in  32  core writeback data.
- mc_issue_i  in  1  multi-cycle op dispatched this cycle.
- mc_issue_addr_i  in  5  destination of the dispatched op.
- mc_valid_i  in  1  multi-cycle result valid.
- mc_addr_i  in  5  result destination.
- mc_data_i  in  32  result data.
- mc_ready_o  out  1  result buffer can accept.
- dec_rs1_addr_i  in  5  decode-stage source 1.
- dec_rs2_addr_i  in  5  decode-stage source 2.
- dec_rd_addr_i  in  5  decode-stage destination.
- dec_rd_en_i  in  1  decode instruction writes rd.
- stall_o  out  1  freeze fetch/decode; core writeback this cycle not committed.
- rd_wren_o  out  1  to regfile write enable.
- rd_addr_o  out  5  to regfile write address.
- rd_data_o  out  32  to regfile write data.
- busy_o  out  32  scoreboard; bit i = result pending for xi.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i. Reset empties the buffer, clears busy_o, the starvation counter and err_o, and sets mc_ready_o=1. rd_wren_o=0 whenever core_wren_i=0 and the buffer is empty. Reset mid-operation discards buffered results; no write is issued after reset release until new requests arrive.
- Buffer:
  - FIFO of {addr,data}, BUF_DEPTH entries; mc_ready_o = !full.
  - Accept on mc_valid_i & mc_ready_o at the clock edge.
  - Head is eligible for commit starting the cycle after acceptance (minimum latency 1 cycle, no bypass).
  - Simultaneous accept and drain when full is not possible, because ready is low when full.
  - Simultaneous accept and drain when non-full keeps the count unchanged.
- Arbitration (combinational, per cycle):
  - Forced drain: starve_cnt==STARVE_MAX and buffer non-empty. Drive head, pop, assert stall_o. core_wren_i is ignored; the core must re-present it next cycle.
  - Otherwise, core_wren_i=1 and core_addr_i!=0: drive core write. If buffer non-empty, increment starve_cnt (saturating).
  - Otherwise, if buffer non-empty: drive head, pop. Core writes to x0 count as idle.
  - Any pop clears starve_cnt.
- x0: writes with address 0 from either source never assert rd_wren_o. Buffered x0 entries are still popped. Busy bit 0 is never set.
- Scoreboard:
  - mc_issue_i sets busy[mc_issue_addr_i] at the edge.
  - A pop clears busy[head addr] at the edge.
  - Same register set and cleared in one cycle: set wins.
  - mc_issue_i to an already-busy register sets err_o and leaves the bit at 1.
  - mc_valid_i with mc_addr_i not busy sets err_o.
- Hazard: stall_o = forced drain OR busy[dec_rs1_addr_i] OR busy[dec_rs2_addr_i] OR (dec_rd_en_i & busy[dec_rd_addr_i]).
  - Index 0 never hits.
  - Busy clears on commit, not on acceptance, so the stall persists until the result is in the regfile.
  - stall_o does not block mc_issue_i or mc results.
- err_o clears only on reset.

Test Plan:
- Issue mul to x5 (mc_issue_i, addr 5) -> busy_o=0x20. Decode with rs1=5 -> stall_o=1. mc result 0xDEADBEEF to x5 with core idle -> accepted; next cycle rd_wren_o=1, addr 5, data 0xDEADBEEF; busy_o=0, stall_o=0 the following cycle.
- Buffer x6=1 with core_wren_i held high writing x7 every cycle -> core wins 4 cycles. 5th cycle: stall_o=1, rd_addr_o=6, core write dropped. Starve counter returns to 0.
- BUF_DEPTH=2 filled with core busy -> mc_ready_o=0, a third mc_valid_i is held and not accepted; after one pop, mc_ready_o=1.
- Core write to x0 with buffered x3 -> x3 commits that cycle. mc result to x0 -> popped, rd_wren_o=0.
- Same-cycle mc_issue_i to x9 and pop of x9 -> busy_o[9]=1. mc_issue_i to busy x4 -> err_o=1 and stays 1.
- Assert rst_ni=0 with 2 entries buffered and busy_o=0x30 -> immediately empty, busy_o=0, mc_ready_o=1, rd_wren_o=0.
